// File: rtl/reg_write_arbiter_if.sv
// Request-side bundle between the writeback sources and the register-bank write arbiter.
// Handshake: a requester raises i_req_valid[k] with select/data and keeps all three stable
// until it sees o_req_ready[k]. The beat transfers on the rising edge where both are high.
// Ready is combinational and may rise in the same cycle as valid.
// Valid may be withdrawn before ready without side effects.
interface reg_write_arbiter_if #(
  parameter int NUM_REQ      = 3,
  parameter int SELECT_WIDTH = 5,
  parameter int DATA_WIDTH   = 32
);
  logic [NUM_REQ-1:0]      i_req_valid;
  logic [SELECT_WIDTH-1:0] i_req_select [NUM_REQ];
  logic [DATA_WIDTH-1:0]   i_req_data   [NUM_REQ];
  logic [NUM_REQ-1:0]      o_req_ready;

  modport master (
    output i_req_valid,
    output i_req_select,
    output i_req_data,
    input  o_req_ready
  );

  modport slave (
    input  i_req_valid,
    input  i_req_select,
    input  i_req_data,
    output o_req_ready
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port between NUM_REQ
// writeback sources, with a registered write stage, range checking and a global hold.
module reg_write_arbiter #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int NUM_REG      = 32,
  parameter  int NUM_REQ      = 3,
  localparam int SELECT_WIDTH = $clog2(NUM_REG),
  localparam int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  reg_write_arbiter_if.slave      req,
  input  logic                    i_hold,
  input  logic                    i_err_clear,
  output logic                    o_write_enable,
  output logic [SELECT_WIDTH-1:0] o_write_select,
  output logic [DATA_WIDTH-1:0]   o_write_data,
  output logic [ID_WIDTH-1:0]     o_grant_id,
  output logic                    o_err_range
);

  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [ID_WIDTH:0]       cand;
  logic [ID_WIDTH-1:0]     grant_id;
  logic                    grant_found;
  logic [SELECT_WIDTH-1:0] grant_select;
  logic [DATA_WIDTH-1:0]   grant_data;
  logic                    sel_in_range;

  // Scan from rr_ptr with wrap-around. Grants are suppressed during reset as well as hold,
  // so no requester is consumed by a beat that reset would drop.
  always_comb begin
    cand        = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
      if (cand >= (ID_WIDTH+1)'(NUM_REQ)) begin
        cand = cand - (ID_WIDTH+1)'(NUM_REQ);
      end
      if (!grant_found && req.i_req_valid[cand[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_WIDTH-1:0];
      end
    end
    if (!rst_n || i_hold) begin
      grant_found = 1'b0;
    end
  end

  assign req.o_req_ready = grant_found ? (NUM_REQ'(1) << grant_id) : '0;
  assign grant_select    = req.i_req_select[grant_id];
  assign grant_data      = req.i_req_data[grant_id];

  // With a power-of-two bank every encodable select is a real register.
  generate
    if (NUM_REG == (2 ** SELECT_WIDTH)) begin : g_full_range
      assign sel_in_range = 1'b1;
    end else begin : g_partial_range
      assign sel_in_range = grant_select < SELECT_WIDTH'(NUM_REG);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      o_write_enable <= 1'b0;
      o_write_select <= '0;
      o_write_data   <= '0;
      o_grant_id     <= '0;
      o_err_range    <= 1'b0;
    end else begin
      o_write_enable <= grant_found && sel_in_range;
      if (grant_found) begin
        rr_ptr <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        if (sel_in_range) begin
          o_write_select <= grant_select;
          o_write_data   <= grant_data;
          o_grant_id     <= grant_id;
        end
      end
      // A new range error takes priority over a clear on the same edge.
      if (grant_found && !sel_in_range) begin
        o_err_range <= 1'b1;
      end else if (i_err_clear) begin
        o_err_range <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic, checked by a
// behavioural model feeding an expected-beat queue that a negedge monitor drains.
module tb_reg_write_arbiter;
  localparam int DW    = 32;
  localparam int NREG  = 24;
  localparam int NREQ  = 3;
  localparam int SW    = $clog2(NREG);
  localparam int IW    = $clog2(NREQ);
  localparam int EXP_W = 1 + SW + DW + IW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  logic err_clear = 1'b0;
  always #5 clk = ~clk;

  logic          we;
  logic [SW-1:0] wsel;
  logic [DW-1:0] wdata;
  logic [IW-1:0] gid;
  logic          err;

  reg_write_arbiter_if #(.NUM_REQ(NREQ), .SELECT_WIDTH(SW), .DATA_WIDTH(DW)) bus ();

  reg_write_arbiter #(.DATA_WIDTH(DW), .NUM_REG(NREG), .NUM_REQ(NREQ)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (bus),
    .i_hold         (hold),
    .i_err_clear    (err_clear),
    .o_write_enable (we),
    .o_write_select (wsel),
    .o_write_data   (wdata),
    .o_grant_id     (gid),
    .o_err_range    (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: first valid requester at or after the pointer, modulo NREQ
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  logic [EXP_W-1:0] exp_q[$];
  int               m_ptr = 0;
  logic             m_live = 1'b0;
  logic             m_we = 1'b0;
  logic [SW-1:0]    m_sel = '0;
  logic [DW-1:0]    m_data = '0;
  logic [IW-1:0]    m_id = '0;
  logic             m_err = 1'b0;
  int               m_g;
  int               m_s;
  logic             m_bad_sel;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ptr = 0; m_we = 1'b0; m_sel = '0; m_data = '0; m_id = '0; m_err = 1'b0;
    end else begin
      m_g       = hold ? -1 : pick(bus.i_req_valid, m_ptr);
      m_we      = 1'b0;
      m_bad_sel = 1'b0;
      if (m_g >= 0) begin
        m_s   = int'(bus.i_req_select[m_g]);
        m_ptr = (m_g + 1) % NREQ;
        if (m_s < NREG) begin
          m_we   = 1'b1;
          m_sel  = bus.i_req_select[m_g];
          m_data = bus.i_req_data[m_g];
          m_id   = IW'(m_g);
        end else begin
          m_bad_sel = 1'b1;
          m_err     = 1'b1;
        end
      end
      if (err_clear && !m_bad_sel) m_err = 1'b0;
    end
    m_live = 1'b1;
    exp_q.push_back({m_we, m_sel, m_data, m_id, m_err});
  end

  // monitor
  logic [EXP_W-1:0] e;
  int               mon_g;
  always @(negedge clk) begin
    if (m_live) begin
      mon_g = (!rst_n || hold) ? -1 : pick(bus.i_req_valid, m_ptr);
      chk("ready", bus.o_req_ready, (mon_g < 0) ? 64'd0 : (64'd1 << mon_g));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write_enable", we,    e[EXP_W-1]);
        chk("write_select", wsel,  e[EXP_W-2 -: SW]);
        chk("write_data",   wdata, e[DW+IW : IW+1]);
        chk("grant_id",     gid,   e[IW:1]);
        chk("err_range",    err,   e[0]);
      end
    end
  end

  // driver
  logic [NREQ-1:0] rdy;
  logic            s_we;
  logic [SW-1:0]   s_sel;
  logic [DW-1:0]   s_data;
  logic [IW-1:0]   s_id;
  logic            s_err;

  // called at posedge+1; snapshots this cycle's outputs, then moves to the next cycle
  task automatic step();
    #3;
    rdy = bus.o_req_ready;
    s_we = we; s_sel = wsel; s_data = wdata; s_id = gid; s_err = err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_req_valid = '1;
    bus.i_req_select[0] = 5'd1; bus.i_req_select[1] = 5'd2; bus.i_req_select[2] = 5'd3;
    for (int k = 0; k < NREQ; k++) bus.i_req_data[k] = $urandom();

    // reset with all requesters valid
    step(); step();
    chk("reset_ready", rdy, 3'b000);
    chk("reset_we", s_we, 1'b0);
    rst_n = 1'b1;

    // round robin from req0
    step();
    chk("first_grant", rdy, 3'b001);
    for (int k = 0; k < NREQ; k++) if (rdy[k]) bus.i_req_data[k] = $urandom();
    for (int c = 1; c < 9; c++) begin
      step();
      chk("rr_seq", rdy, 64'd1 << (c % NREQ));
      if (c > 1) chk("rr_id", s_id, (c - 1) % NREQ);
      for (int k = 0; k < NREQ; k++) if (rdy[k]) bus.i_req_data[k] = $urandom();
    end

    // latency and data
    bus.i_req_valid = 3'b100; bus.i_req_select[2] = 5'd5; bus.i_req_data[2] = 32'hDEADBEEF;
    step();
    chk("lat_ready", rdy, 3'b100);
    bus.i_req_valid = '0;
    step();
    chk("lat_we", s_we, 1'b1);
    chk("lat_sel", s_sel, 5'd5);
    chk("lat_data", s_data, 32'hDEADBEEF);
    chk("lat_id", s_id, 2'd2);
    step();
    chk("lat_we_off", s_we, 1'b0);

    // move pointer to 2, then hold with everything valid
    bus.i_req_valid = 3'b010; bus.i_req_select[1] = 5'd7;
    step();
    chk("pre_hold", rdy, 3'b010);
    bus.i_req_valid = '1; hold = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("hold_ready", rdy, 3'b000);
    end
    hold = 1'b0;
    step();
    chk("post_hold", rdy, 3'b100);
    bus.i_req_valid = '0;

    // out-of-range select
    bus.i_req_valid = 3'b010; bus.i_req_select[1] = 5'd30;
    step();
    chk("range_ready", rdy, 3'b010);
    bus.i_req_valid = '0;
    step();
    chk("range_we", s_we, 1'b0);
    chk("range_err", s_err, 1'b1);
    step();
    chk("range_sticky", s_err, 1'b1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    step();
    chk("range_cleared", s_err, 1'b0);
    bus.i_req_valid = 3'b010; bus.i_req_select[1] = 5'd31; err_clear = 1'b1;
    step();
    bus.i_req_valid = '0; err_clear = 1'b0;
    step();
    chk("set_beats_clear", s_err, 1'b1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;

    // single requester at full throughput
    bus.i_req_valid = 3'b001; bus.i_req_select[0] = 5'd4;
    for (int c = 0; c < 4; c++) begin
      bus.i_req_data[0] = $urandom();
      step();
      chk("single_ready", rdy, 3'b001);
      if (c > 0) chk("single_we", s_we, 1'b1);
    end
    bus.i_req_valid = '0;
    step();

    // reset lands on the edge ending a transfer cycle
    bus.i_req_valid = 3'b001; bus.i_req_select[0] = 5'd9; bus.i_req_data[0] = 32'h1234;
    #3;
    chk("midrst_ready", bus.o_req_ready, 3'b001);
    #4;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_req_valid = '0;
    step();
    chk("midrst_we", s_we, 1'b0);
    chk("midrst_data", s_data, 32'h0);
    step();
    chk("midrst_never", s_we, 1'b0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      hold      = ($urandom_range(0, 9) == 0);
      err_clear = ($urandom_range(0, 9) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      for (int k = 0; k < NREQ; k++) begin
        if (bus.i_req_valid[k] && rdy[k]) bus.i_req_valid[k] = 1'b0;
        else if (bus.i_req_valid[k] && $urandom_range(0, 31) == 0) bus.i_req_valid[k] = 1'b0;
        if (!bus.i_req_valid[k] && $urandom_range(0, 1) == 1) begin
          bus.i_req_valid[k]  = 1'b1;
          bus.i_req_select[k] = SW'($urandom_range(0, 31));
          bus.i_req_data[k]   = $urandom();
        end
      end
    end
    rst_n = 1'b1; hold = 1'b0; err_clear = 1'b0; bus.i_req_valid = '0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
